// File: rtl/barrett_reducer.sv
// barrett_reducer: three-stage Barrett modular reduction of a 2N-bit product
// by a compile-time modulus Q. Valid/ready streaming with a single global
// advance signal, so the pipeline moves as one unit and holds on a stall.
module barrett_reducer #(
   parameter int N = 16,
   parameter int Q = 12289
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*N-1:0] in_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   out_data
);

   // Barrett constants: K is the shift base, MU the scaled reciprocal of Q.
   localparam int K   = $clog2(Q);
   localparam int RW  = K + 2;             // residue width before correction (< 3Q)
   localparam int SW  = 2*N - K + 1;       // width of in_data >> (K-1)
   localparam int T1W = SW + K + 1;        // width of the quotient-estimate product
   localparam int QHW = T1W - (K + 1);     // width of the quotient estimate

   localparam logic [K:0]     MU  = (K+1)'((64'd1 << (2*K)) / 64'(Q));
   localparam logic [RW-1:0]  Q_R = RW'(Q);
   localparam logic [T1W-1:0] Q_T = T1W'(Q);

   // Pipeline state
   logic [2*N-1:0] x1_q, x1_d;
   logic [T1W-1:0] t1_q, t1_d;
   logic           v1_q, v1_d;
   logic [RW-1:0]  r2_q, r2_d;
   logic           v2_q, v2_d;
   logic [N-1:0]   out_data_q, out_data_d;
   logic           out_valid_q, out_valid_d;

   logic           adv_s;
   logic [QHW-1:0] qh_s;
   logic [T1W-1:0] qhq_s;
   logic [RW-1:0]  r3_s;
   logic           unused_bits_s;

   // Global advance: the whole pipeline moves unless the output is held.
   assign adv_s     = ~out_valid_q | out_ready;
   assign in_ready  = adv_s;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

   // Only the top bits of t1 and the low bits of x1 feed the arithmetic.
   assign unused_bits_s = ^{t1_q[K:0], x1_q[2*N-1:RW]};

   // S1 capture: raw product plus the scaled quotient estimate product.
   always_comb begin
      x1_d = in_data;
      t1_d = T1W'(in_data >> (K - 1)) * T1W'(MU);
      v1_d = in_valid;
   end

   // S2 estimate: r2 = x1 - qh*Q, computed modulo 2^RW since r2 < 3Q.
   always_comb begin
      qh_s  = t1_q[T1W-1:K+1];
      qhq_s = T1W'(qh_s) * Q_T;
      r2_d  = RW'(x1_q) - RW'(qhq_s);
      v2_d  = v1_q;
   end

   // S3 correct: at most two conditional subtractions bring r into 0..Q-1.
   always_comb begin
      r3_s = r2_q;
      if (r3_s >= Q_R) begin
         r3_s = r3_s - Q_R;
      end else begin
         r3_s = r3_s;
      end
      if (r3_s >= Q_R) begin
         r3_s = r3_s - Q_R;
      end else begin
         r3_s = r3_s;
      end
      out_data_d  = N'(r3_s);
      out_valid_d = v2_q;
   end

   // Pipeline registers: synchronous clear, shift on advance, hold on stall.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x1_q        <= '0;
         t1_q        <= '0;
         v1_q        <= 1'b0;
         r2_q        <= '0;
         v2_q        <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else if (adv_s) begin
         x1_q        <= x1_d;
         t1_q        <= t1_d;
         v1_q        <= v1_d;
         r2_q        <= r2_d;
         v2_q        <= v2_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end else begin
         x1_q        <= x1_q;
         t1_q        <= t1_q;
         v1_q        <= v1_q;
         r2_q        <= r2_q;
         v2_q        <= v2_q;
         out_data_q  <= out_data_q;
         out_valid_q <= out_valid_q;
      end
   end

endmodule

// File: tb/tb_barrett_reducer.sv
// Directed and random self-checking bench for barrett_reducer (N=16, Q=12289).
module tb_barrett_reducer;

   localparam int N = 16;
   localparam int Q = 12289;

   typedef struct {
      logic [15:0] exp;
      int          cyc;
   } item_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [2*N-1:0] in_data;
   logic           out_valid;
   logic           out_ready;
   logic [N-1:0]   out_data;

   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   item_t       sb_q[$];
   logic [15:0] cur_exp;
   bit          chk_lat;
   bit          last_in_xfer;
   bit          last_ov;
   bit          hold_prev;
   logic [15:0] hold_data;

   int          acc;
   int          idx;
   int          nvalid;
   logic [31:0] bp [5];
   logic [5:0]  ovp;
   logic [5:0]  pat;
   logic [31:0] a, b, p;
   bit          v;

   always #5 clk = ~clk;

   barrett_reducer #(.N(N), .Q(Q)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   function automatic logic [15:0] ref_mod(input logic [31:0] x);
      return 16'(x % 32'(Q));
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock cycle: sample at negedge, score transfers, return just after posedge.
   task automatic cycle();
      item_t it;
      @(negedge clk);
      cyc++;
      last_ov      = out_valid;
      last_in_xfer = rst_n && in_valid && in_ready;
      if (rst_n) begin
         if (hold_prev) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", 64'(out_data), 64'(hold_data));
         end
         if (out_valid && out_ready) begin
            check("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
               it = sb_q.pop_front();
               check("data", 64'(out_data), 64'(it.exp));
               if (chk_lat) check("latency", 64'(cyc - it.cyc), 64'd3);
            end
         end
         if (last_in_xfer) sb_q.push_back('{cur_exp, cyc});
         hold_prev = out_valid && !out_ready;
         hold_data = out_data;
      end else begin
         hold_prev = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit vv, input logic [31:0] d, input logic [15:0] e);
      in_valid = vv;
      in_data  = d;
      cur_exp  = e;
      cycle();
   endtask

   task automatic drain();
      int n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (sb_q.size() > 0 && n < 40) begin
         cycle();
         n++;
      end
      repeat (3) cycle();
      check("drain_empty", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      cur_exp   = '0;
      chk_lat   = 1'b0;
      hold_prev = 1'b0;
      hold_data = '0;
      cycle();
      cycle();
      rst_n = 1'b1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // Basic values, back-to-back, latency 3 and no gaps
      out_ready = 1'b1;
      chk_lat   = 1'b1;
      drive(1'b1, 32'd0,     16'd0);
      drive(1'b1, 32'd1,     16'd1);
      drive(1'b1, 32'd12288, 16'd12288);
      drive(1'b1, 32'd12289, 16'd0);
      drive(1'b1, 32'd12290, 16'd1);
      drain();

      // Max legal input and a general product
      drive(1'b1, 32'd150994944, 16'd1);
      drive(1'b1, 32'd83810205, ref_mod(32'd12345 * 32'd6789));
      drive(1'b1, 32'd24577, 16'd12288);
      drain();

      // Back-pressure: three accepted, then stall with stable output
      chk_lat   = 1'b0;
      out_ready = 1'b0;
      bp        = '{32'd1000, 32'd2000000, 32'd99999, 32'd150994944, 32'd7};
      acc = 0;
      idx = 0;
      repeat (6) begin
         drive(1'b1, bp[idx], ref_mod(bp[idx]));
         if (last_in_xfer) begin
            acc++;
            idx++;
         end
      end
      check("bp_accepted", 64'(acc), 64'd3);
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_data", 64'(out_data), 64'(ref_mod(32'd1000)));
      out_ready = 1'b1;
      #1;
      check("bp_in_ready_release", 64'(in_ready), 64'd1);
      drive(1'b1, bp[idx], ref_mod(bp[idx]));
      check("bp_release_accept", 64'(last_in_xfer), 64'd1);
      idx++;
      drive(1'b1, bp[idx], ref_mod(bp[idx]));
      drain();

      // Bubbles propagate unchanged
      chk_lat = 1'b1;
      pat     = 6'b100101;
      ovp     = '0;
      for (int i = 0; i < 9; i++) begin
         v = (i < 6) ? pat[i] : 1'b0;
         drive(v, 32'(5000 + i * 7777), ref_mod(32'(5000 + i * 7777)));
         if (i >= 3) ovp[i-3] = last_ov;
      end
      check("bubble_pattern", 64'(ovp), 64'(pat));
      drain();

      // Reset with three items in flight
      chk_lat   = 1'b0;
      out_ready = 1'b0;
      drive(1'b1, 32'd111, 16'd111);
      drive(1'b1, 32'd22222, 16'd9933);
      drive(1'b1, 32'd150994944, 16'd1);
      check("rst_pre_full", 64'(out_valid), 64'd1);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      cycle();
      rst_n = 1'b1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_out_data", 64'(out_data), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      sb_q.delete();
      out_ready = 1'b1;
      nvalid    = 0;
      repeat (6) begin
         drive(1'b0, 32'd0, 16'd0);
         if (last_ov) nvalid++;
      end
      check("midrst_no_stale", 64'(nvalid), 64'd0);

      // Random products with random back-pressure
      repeat (3000) begin
         a = 32'($urandom_range(0, Q - 1));
         b = 32'($urandom_range(0, Q - 1));
         p = a * b;
         v = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         drive(v, p, ref_mod(p));
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
